// File: rtl/bus_lcd_monitor.sv
// Passive serial-bus snooper that rate-limits and formats the last good frame for the LCD.
// Define BUS_MON_ERRCNT_EN to build the saturating protocol error counter on err_cnt.
module bus_lcd_monitor #(
   parameter int ADDR_W      = 14,
   parameter int DATA_W      = 8,
   parameter int HOLD_CYCLES = 50000000
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        bus_sdata,
   input  logic        bus_addr_vld,
   input  logic        bus_data_vld,
   input  logic [1:0]  bus_mst,
   input  logic [1:0]  bus_slv,
   input  logic        bus_done,
   input  logic        page_btn,
   output logic [15:0] Data_Line1,
   output logic [15:0] Data_Line2,
   output logic [1:0]  Data_Type1,
   output logic [1:0]  Data_Type2,
   output logic        upd,
   output logic [7:0]  err_cnt
);

   localparam int ACW = $clog2(ADDR_W + 2);
   localparam int DCW = $clog2(DATA_W + 2);
   localparam int TW  = $clog2(HOLD_CYCLES);

   localparam logic [ACW-1:0] ACNT_FULL = ACW'(ADDR_W);
   localparam logic [ACW-1:0] ACNT_OVER = ACW'(ADDR_W + 1);
   localparam logic [DCW-1:0] DCNT_FULL = DCW'(DATA_W);
   localparam logic [DCW-1:0] DCNT_OVER = DCW'(DATA_W + 1);
   localparam logic [TW-1:0]  HOLD_MAX  = TW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      CHECK
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] asr_q, asr_d;
   logic [DATA_W-1:0] dsr_q, dsr_d;
   logic [ACW-1:0]    acnt_q, acnt_d;
   logic [DCW-1:0]    dcnt_q, dcnt_d;
   logic              ferr_q, ferr_d;
   logic              fresh, active, chk_ok_d;

   logic              chk_ok_q;
   logic [ADDR_W-1:0] chk_addr_q;
   logic [DATA_W-1:0] chk_data_q;
   logic [1:0]        chk_mst_q, chk_slv_q;

   logic [ADDR_W-1:0] sh_addr_q, dp_addr_q, src_addr;
   logic [DATA_W-1:0] sh_data_q, dp_data_q, src_data;
   logic [1:0]        sh_mst_q, dp_mst_q, src_mst;
   logic [1:0]        sh_slv_q, dp_slv_q, src_slv;

   logic              pending_q, page_q, page_d;
   logic [TW-1:0]     timer_q;
   logic              show, new_frame;
   logic [15:0]       line1_d, line2_d;
   logic [1:0]        type1_d, type2_d;

   // CHECK behaves like IDLE for a following frame, so its first bit is kept.
   always_comb begin
      fresh  = (state_q == IDLE) || (state_q == CHECK);
      active = !fresh || bus_addr_vld;
      asr_d  = fresh ? '0 : asr_q;
      dsr_d  = fresh ? '0 : dsr_q;
      acnt_d = fresh ? '0 : acnt_q;
      dcnt_d = fresh ? '0 : dcnt_q;
      ferr_d = fresh ? 1'b0 : ferr_q;

      if (bus_addr_vld && (bus_data_vld || state_q == DATA))
         ferr_d = 1'b1;

      if (bus_addr_vld) begin
         if (acnt_d < ACNT_FULL) begin
            asr_d  = (asr_d << 1) | ADDR_W'(bus_sdata);
            acnt_d = acnt_d + ACW'(1);
         end else begin
            acnt_d = ACNT_OVER;
            ferr_d = 1'b1;
         end
      end

      if (active && bus_data_vld) begin
         if (dcnt_d < DCNT_FULL) begin
            dsr_d  = (dsr_d << 1) | DATA_W'(bus_sdata);
            dcnt_d = dcnt_d + DCW'(1);
         end else begin
            dcnt_d = DCNT_OVER;
            ferr_d = 1'b1;
         end
      end

      chk_ok_d = (acnt_d == ACNT_FULL) &&
                 (dcnt_d == DCNT_FULL) && !ferr_d;

      if (bus_done)
         state_d = CHECK;
      else if (!active)
         state_d = IDLE;
      else if (bus_data_vld)
         state_d = DATA;
      else if (fresh)
         state_d = ADDR;
      else
         state_d = state_q;
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         asr_q      <= '0;
         dsr_q      <= '0;
         acnt_q     <= '0;
         dcnt_q     <= '0;
         ferr_q     <= 1'b0;
         chk_ok_q   <= 1'b0;
         chk_addr_q <= '0;
         chk_data_q <= '0;
         chk_mst_q  <= '0;
         chk_slv_q  <= '0;
      end else begin
         state_q <= state_d;
         asr_q   <= asr_d;
         dsr_q   <= dsr_d;
         acnt_q  <= acnt_d;
         dcnt_q  <= dcnt_d;
         ferr_q  <= ferr_d;
         if (bus_done) begin
            chk_ok_q   <= chk_ok_d;
            chk_addr_q <= asr_d;
            chk_data_q <= dsr_d;
            chk_mst_q  <= bus_mst;
            chk_slv_q  <= bus_slv;
         end
      end
   end

   assign new_frame = (state_q == CHECK) && chk_ok_q;
   assign show      = pending_q && (timer_q == '0);
   assign page_d    = page_q ^ page_btn;

   // An update formats the shadow; a bare page flip re-formats the displayed snapshot.
   always_comb begin
      src_addr = show ? sh_addr_q : dp_addr_q;
      src_data = show ? sh_data_q : dp_data_q;
      src_mst  = show ? sh_mst_q  : dp_mst_q;
      src_slv  = show ? sh_slv_q  : dp_slv_q;
      if (page_d) begin
         line1_d = {14'b0, src_mst};
         line2_d = {14'b0, src_slv};
         type1_d = 2'd2;
         type2_d = 2'd3;
      end else begin
         line1_d = 16'(src_addr);
         line2_d = 16'(src_data);
         type1_d = 2'd0;
         type2_d = 2'd1;
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         sh_addr_q  <= '0;
         sh_data_q  <= '0;
         sh_mst_q   <= '0;
         sh_slv_q   <= '0;
         dp_addr_q  <= '0;
         dp_data_q  <= '0;
         dp_mst_q   <= '0;
         dp_slv_q   <= '0;
         pending_q  <= 1'b0;
         page_q     <= 1'b0;
         timer_q    <= '0;
         upd        <= 1'b0;
         Data_Line1 <= 16'd0;
         Data_Line2 <= 16'd0;
         Data_Type1 <= 2'd0;
         Data_Type2 <= 2'd1;
      end else begin
         if (new_frame) begin
            sh_addr_q <= chk_addr_q;
            sh_data_q <= chk_data_q;
            sh_mst_q  <= chk_mst_q;
            sh_slv_q  <= chk_slv_q;
         end
         pending_q <= new_frame || (pending_q && !show);
         page_q    <= page_d;

         if (show)
            timer_q <= HOLD_MAX;
         else if (timer_q != '0)
            timer_q <= timer_q - TW'(1);

         if (show) begin
            dp_addr_q <= sh_addr_q;
            dp_data_q <= sh_data_q;
            dp_mst_q  <= sh_mst_q;
            dp_slv_q  <= sh_slv_q;
         end

         upd <= show || page_btn;
         if (show || page_btn) begin
            Data_Line1 <= line1_d;
            Data_Line2 <= line2_d;
            Data_Type1 <= type1_d;
            Data_Type2 <= type2_d;
         end
      end
   end

`ifdef BUS_MON_ERRCNT_EN
   logic [7:0] err_q;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst)
         err_q <= 8'd0;
      else if ((state_q == CHECK) && !chk_ok_q && (err_q != 8'hFF))
         err_q <= err_q + 8'd1;
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 8'd0;
`endif

endmodule
